axi_lite_sram: RTL and testbench

AXI4-Lite slave giving the NPC core a simulated SRAM backed by the DPI memory model (`n_pmem_read` / `n_pmem_write`). Parametrised successor of the single-width, fixed-latency SRAM slave:
- configurable data width, address window and read/write latency;
- optional pseudo-random latency mode;
- AW and W accepted in either order;
- OKAY / SLVERR / DECERR responses.

It sits behind the core's instruction or data AXI master port, or behind the crossbar.

---
 rtl/axi_sram_pkg.sv | 36 +++
 rtl/delay_lfsr.sv | 13 +
 rtl/axi_lite_sram.sv | 160 ++++++++++++++++
 tb/tb_axi_lite_sram.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_pkg.sv
// Shared types for the AXI4-Lite SRAM slave, plus the simulated physical
// memory reached through the n_pmem_read / n_pmem_write entry points.
package axi_sram_pkg;

  typedef enum logic [1:0] {OKAY = 2'd0, SLVERR = 2'd2, DECERR = 2'd3} resp_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Sparse word-indexed backing store; call counters expose memory traffic.
  logic [31:0] pmem [int unsigned];
  int unsigned pmem_rd_calls;
  int unsigned pmem_wr_calls;

  function automatic logic [31:0] n_pmem_read(input logic [31:0] addr);
    int unsigned k;
    k = {2'b00, addr[31:2]};
    pmem_rd_calls = pmem_rd_calls + 1;
    if (pmem.exists(k)) return pmem[k];
    return 32'h0;
  endfunction

  function automatic void n_pmem_write(input logic [31:0] addr, input logic [31:0] data,
                                       input logic [3:0] mask);
    int unsigned k;
    logic [31:0] w;
    k = {2'b00, addr[31:2]};
    pmem_wr_calls = pmem_wr_calls + 1;
    w = pmem.exists(k) ? pmem[k] : 32'h0;
    for (int b = 0; b < 4; b++)
      if (mask[b]) w[b*8 +: 8] = data[b*8 +: 8];
    pmem[k] = w;
  endfunction

endpackage

// File: rtl/delay_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) used to draw latencies.
module delay_lfsr import axi_sram_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] lfsr
);

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave over the simulated physical memory: independent read and
// write FSMs, fixed or pseudo-random latency, address window / alignment checks.
module axi_lite_sram import axi_sram_pkg::*; #(
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE      = 32'h0800_0000,
  parameter int          READ_LATENCY  = 1,
  parameter int          WRITE_LATENCY = 1,
  parameter bit          RAND_DELAY    = 1'b0
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [31:0]             araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [31:0]             awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic                    bvalid,
  output logic [1:0]              bresp,
  input  logic                    bready
);

  localparam int NWORDS = DATA_WIDTH / 32;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = 16;

  // 33-bit compare so a window ending at 2^32 still works.
  function automatic resp_t addr_check(input logic [31:0] a);
    logic [32:0] lo, hi;
    lo = {1'b0, BASE_ADDR};
    hi = lo + {1'b0, MEM_SIZE};
    if ({1'b0, a} < lo || {1'b0, a} >= hi) return DECERR;
    if ((a & 32'(STRB_W - 1)) != 32'h0) return SLVERR;
    return OKAY;
  endfunction

  function automatic logic [CNT_W-1:0] delay_load(input logic [7:0] r, input int lat);
    if (RAND_DELAY) return CNT_W'(1 + ({24'd0, r} % lat));
    return CNT_W'(lat);
  endfunction

  logic       ready_en;
  logic [7:0] rd_lfsr, wr_lfsr;

  delay_lfsr u_rd_lfsr (.clk(aclk), .reset(areset), .lfsr(rd_lfsr));
  delay_lfsr u_wr_lfsr (.clk(aclk), .reset(areset), .lfsr(wr_lfsr));

  always_ff @(posedge aclk) ready_en <= ~areset;

  // ---------------- read path ----------------
  rd_state_t        rd_state;
  logic [31:0]      rd_addr;
  logic [CNT_W-1:0] rd_cnt;

  assign arready = ready_en && (rd_state == R_IDLE);
  assign rvalid  = (rd_state == R_RESP);

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state <= R_IDLE;
      rd_addr  <= '0;
      rd_cnt   <= '0;
      rdata    <= '0;
      rresp    <= OKAY;
    end else begin
      case (rd_state)
        R_IDLE: if (arvalid && arready) begin
          rd_addr  <= araddr;
          rd_cnt   <= delay_load(rd_lfsr, READ_LATENCY);
          rd_state <= R_WAIT;
        end
        R_WAIT: if (rd_cnt == CNT_W'(1)) begin
          rresp <= addr_check(rd_addr);
          if (addr_check(rd_addr) == OKAY) begin
            for (int i = 0; i < NWORDS; i++)
              rdata[i*32 +: 32] <= n_pmem_read(rd_addr + 32'(4 * i));
          end else begin
            rdata <= '0;
          end
          rd_state <= R_RESP;
        end else begin
          rd_cnt <= rd_cnt - CNT_W'(1);
        end
        R_RESP: if (rready) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- write path ----------------
  wr_state_t        wr_state;
  logic             aw_got, w_got, aw_hs, w_hs;
  logic [31:0]      wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [CNT_W-1:0] wr_cnt;

  assign awready = ready_en && (wr_state == W_IDLE) && !aw_got;
  assign wready  = ready_en && (wr_state == W_IDLE) && !w_got;
  assign bvalid  = (wr_state == W_RESP);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state <= W_IDLE;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_strb  <= '0;
      wr_cnt   <= '0;
      bresp    <= OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            wr_addr <= awaddr;
            aw_got  <= 1'b1;
          end
          if (w_hs) begin
            wr_data <= wdata;
            wr_strb <= wstrb;
            w_got   <= 1'b1;
          end
          // Start timing from the edge that completes the pair.
          if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            wr_cnt   <= delay_load(wr_lfsr, WRITE_LATENCY);
            wr_state <= W_WAIT;
          end
        end
        W_WAIT: if (wr_cnt == CNT_W'(1)) begin
          bresp <= addr_check(wr_addr);
          if (addr_check(wr_addr) == OKAY)
            for (int i = 0; i < NWORDS; i++)
              n_pmem_write(wr_addr + 32'(4 * i), wr_data[i*32 +: 32], wr_strb[i*4 +: 4]);
          wr_state <= W_RESP;
        end else begin
          wr_cnt <= wr_cnt - CNT_W'(1);
        end
        W_RESP: if (bready) begin
          aw_got   <= 1'b0;
          w_got    <= 1'b0;
          wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_sram.sv
// Directed bench: a 32-bit fixed-latency slave and a 64-bit random-latency
// slave sharing the simulated memory, checked against a local memory model.
module tb_axi_lite_sram;
  import axi_sram_pkg::*;

  localparam int          RL   = 3;
  localparam int          WL   = 4;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SIZE = 32'h0800_0000;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  // slave A: 32-bit, fixed latency
  logic [31:0] a_araddr, a_rdata, a_awaddr, a_wdata;
  logic [3:0]  a_wstrb;
  logic [1:0]  a_rresp, a_bresp;
  logic a_arvalid, a_arready, a_rvalid, a_rready, a_awvalid, a_awready;
  logic a_wvalid, a_wready, a_bvalid, a_bready;

  // slave B: 64-bit, random latency, read-only use
  logic [31:0] b_araddr;
  logic [63:0] b_rdata;
  logic [1:0]  b_rresp, b_bresp;
  logic b_arvalid, b_arready, b_rvalid, b_rready, b_awready, b_wready, b_bvalid;

  axi_lite_sram #(.DATA_WIDTH(32), .READ_LATENCY(RL), .WRITE_LATENCY(WL), .RAND_DELAY(1'b0)) u_dut_a (
    .aclk(aclk), .areset(areset),
    .araddr(a_araddr), .arvalid(a_arvalid), .arready(a_arready),
    .rdata(a_rdata), .rresp(a_rresp), .rvalid(a_rvalid), .rready(a_rready),
    .awaddr(a_awaddr), .awvalid(a_awvalid), .awready(a_awready),
    .wdata(a_wdata), .wstrb(a_wstrb), .wvalid(a_wvalid), .wready(a_wready),
    .bvalid(a_bvalid), .bresp(a_bresp), .bready(a_bready)
  );

  axi_lite_sram #(.DATA_WIDTH(64), .READ_LATENCY(4), .WRITE_LATENCY(1), .RAND_DELAY(1'b1)) u_dut_b (
    .aclk(aclk), .areset(areset),
    .araddr(b_araddr), .arvalid(b_arvalid), .arready(b_arready),
    .rdata(b_rdata), .rresp(b_rresp), .rvalid(b_rvalid), .rready(b_rready),
    .awaddr(32'h0), .awvalid(1'b0), .awready(b_awready),
    .wdata(64'h0), .wstrb(8'h0), .wvalid(1'b0), .wready(b_wready),
    .bvalid(b_bvalid), .bresp(b_bresp), .bready(1'b1)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic [7:0]  lat;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [int unsigned];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [31:0] a);
    int unsigned k;
    k = {2'b00, a[31:2]};
    return model.exists(k) ? model[k] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a, input int bytes);
    if (a < BASE || {1'b0, a} >= ({1'b0, BASE} + {1'b0, SIZE})) return 2'd3;
    if (a % 32'(bytes) != 32'h0) return 2'd2;
    return 2'd0;
  endfunction

  task automatic a_read(input logic [31:0] addr, input int hold);
    exp_t e, got;
    int n, lat;
    int unsigned c0;
    e.resp = exp_resp(addr, 4);
    e.data = {32'h0, (e.resp == 2'd0) ? mrd(addr) : 32'h0};
    e.lat  = 8'(RL);
    sbq.push_back(e);
    c0 = pmem_rd_calls;
    a_rready = (hold == 0);
    @(negedge aclk);
    a_araddr = addr;
    a_arvalid = 1'b1;
    n = 0;
    while (!a_arready && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    a_arvalid = 1'b0;
    lat = 0;
    while (!a_rvalid && lat < 50) begin @(negedge aclk); lat++; end
    got = sbq.pop_front();
    chk("rd_latency", 64'(lat), 64'(got.lat));
    chk("rd_data", 64'(a_rdata), got.data);
    chk("rd_resp", 64'(a_rresp), 64'(got.resp));
    chk("rd_mem_calls", 64'(pmem_rd_calls - c0), 64'((got.resp == 2'd0) ? 1 : 0));
    for (int k = 0; k < hold; k++) begin
      chk("hold_rvalid", 64'(a_rvalid), 64'(1));
      chk("hold_rdata", 64'(a_rdata), got.data);
      chk("hold_arready", 64'(a_arready), 64'(0));
      @(negedge aclk);
    end
    a_rready = 1'b1;
    @(negedge aclk);
    chk("rd_rvalid_drop", 64'(a_rvalid), 64'(0));
    chk("rd_next_arready", 64'(a_arready), 64'(1));
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic a_write(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int lead);
    exp_t e, got;
    int t, tw, ta, lat;
    bit wd, ad, wp, ap;
    int unsigned c0;
    logic [31:0] w;
    e.resp = exp_resp(addr, 4);
    e.data = '0;
    e.lat  = 8'(WL);
    sbq.push_back(e);
    if (e.resp == 2'd0) begin
      w = mrd(addr);
      for (int b = 0; b < 4; b++) if (strb[b]) w[b*8 +: 8] = data[b*8 +: 8];
      model[{2'b00, addr[31:2]}] = w;
    end
    c0 = pmem_wr_calls;
    tw = (lead > 0) ? 0 : -lead;
    ta = (lead > 0) ? lead : 0;
    {wd, ad, wp, ap} = 4'b0;
    t = 0;
    a_awaddr = addr;
    a_wdata = data;
    a_wstrb = strb;
    while (!(wd && ad) && t < 60) begin
      @(negedge aclk);
      if (wp) begin a_wvalid = 1'b0; wd = 1'b1; end
      if (ap) begin a_awvalid = 1'b0; ad = 1'b1; end
      if (t == tw && !wd) a_wvalid = 1'b1;
      if (t == ta && !ad) a_awvalid = 1'b1;
      wp = a_wvalid && a_wready;
      ap = a_awvalid && a_awready;
      if (wd && !ad) chk("wready_after_capture", 64'(a_wready), 64'(0));
      if (ad && !wd) chk("awready_after_capture", 64'(a_awready), 64'(0));
      t++;
    end
    lat = 0;
    while (!a_bvalid && lat < 60) begin @(negedge aclk); lat++; end
    got = sbq.pop_front();
    chk("wr_latency", 64'(lat), 64'(got.lat));
    chk("wr_bresp", 64'(a_bresp), 64'(got.resp));
    chk("wr_mem_calls", 64'(pmem_wr_calls - c0), 64'((got.resp == 2'd0) ? 1 : 0));
    @(negedge aclk);
    chk("wr_bvalid_drop", 64'(a_bvalid), 64'(0));
    chk("wr_next_awready", 64'(a_awready), 64'(1));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int unsigned c0;
    int n, lat;
    bit saw_b;
    logic [31:0] addr;
    logic [4:0] seen;
    exp_t e, got;

    {a_arvalid, a_awvalid, a_wvalid, b_arvalid} = 4'b0;
    {a_rready, a_bready, b_rready} = 3'b111;
    a_araddr = '0; a_awaddr = '0; a_wdata = '0; a_wstrb = '0; b_araddr = '0;

    repeat (3) @(negedge aclk);
    chk("rst_arready", 64'(a_arready), 64'(0));
    chk("rst_awready", 64'(a_awready), 64'(0));
    chk("rst_wready", 64'(a_wready), 64'(0));
    chk("rst_rvalid", 64'(a_rvalid), 64'(0));
    chk("rst_bvalid", 64'(a_bvalid), 64'(0));
    chk("rst_resps", 64'({a_rresp, a_bresp}), 64'(0));
    chk("rst_rdata", 64'(a_rdata), 64'(0));
    chk("rst_b_readies", 64'({b_arready, b_awready, b_wready}), 64'(0));
    areset = 1'b0;
    @(negedge aclk);
    chk("ready_after_reset", 64'(a_arready), 64'(1));

    a_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    a_read(32'h8000_0010, 0);
    a_write(32'h8000_0020, 32'h1122_3344, 4'b0101, 2);
    a_read(32'h8000_0020, 0);
    chk("strobe_merge", 64'(mrd(32'h8000_0020)), 64'h0022_0044);
    a_write(32'h8000_0024, 32'hA5A5_5A5A, 4'hF, -3);
    a_read(32'h8000_0024, 0);
    a_read(32'h7FFF_FFFC, 0);
    a_write(32'h8000_0002, 32'hFFFF_FFFF, 4'hF, 0);
    a_read(32'h8000_0000, 0);
    a_read(32'h8000_0002, 0);
    a_write(32'h87FF_FFFC, 32'h0BAD_CAFE, 4'hF, 1);
    a_read(32'h87FF_FFFC, 0);
    a_read(32'h8800_0000, 0);
    a_write(32'h8800_0000, 32'h1234_5678, 4'hF, 0);
    a_read(32'h8000_0010, 5);

    // Reset while the write is waiting out its latency.
    c0 = pmem_wr_calls;
    a_awaddr = 32'h8000_0040; a_wdata = 32'hCAFE_F00D; a_wstrb = 4'hF;
    a_awvalid = 1'b1; a_wvalid = 1'b1;
    @(negedge aclk);
    a_awvalid = 1'b0; a_wvalid = 1'b0;
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    chk("abort_readies", 64'({a_arready, a_awready, a_wready}), 64'(0));
    chk("abort_valids", 64'({a_rvalid, a_bvalid}), 64'(0));
    chk("abort_payload", 64'({a_rresp, a_bresp, a_rdata}), 64'(0));
    areset = 1'b0;
    saw_b = 1'b0;
    repeat (10) begin @(negedge aclk); saw_b |= a_bvalid; end
    chk("abort_no_bvalid", 64'(saw_b), 64'(0));
    chk("abort_no_mem_write", 64'(pmem_wr_calls - c0), 64'(0));
    a_read(32'h8000_0040, 0);

    for (int i = 0; i < 16; i++)
      a_write(BASE + 32'(4 * i), $urandom, 4'hF, (i % 3) - 1);

    // Back-to-back reads on the random-latency 64-bit slave.
    seen = '0;
    @(negedge aclk);
    for (int i = 0; i < 200; i++) begin
      addr = BASE + 32'(8 * $urandom_range(0, 7));
      e.data = {mrd(addr + 32'd4), mrd(addr)};
      e.resp = exp_resp(addr, 8);
      e.lat = 8'd0;
      sbq.push_back(e);
      b_araddr = addr;
      b_arvalid = 1'b1;
      n = 0;
      while (!b_arready && n < 50) begin @(negedge aclk); n++; end
      @(negedge aclk);
      b_arvalid = 1'b0;
      lat = 0;
      while (!b_rvalid && lat < 50) begin @(negedge aclk); lat++; end
      got = sbq.pop_front();
      chk("rnd_data", b_rdata, got.data);
      chk("rnd_resp", 64'(b_rresp), 64'(got.resp));
      chk("rnd_latency_range", 64'(lat >= 1 && lat <= 4), 64'(1));
      if (lat >= 1 && lat <= 4) seen[lat] = 1'b1;
      @(negedge aclk);
    end
    chk("rnd_all_latencies", 64'(seen[4:1]), 64'(4'hF));
    chk("b_write_idle", 64'({b_bvalid, b_bresp}), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
